serial_mag_compare: RTL and testbench

- Downstream consumer of the 2-bit comparator's 6-bit flag vector.
- Accumulates per-digit flags for a multi-digit word, presented MSB digit-pair first, one digit pair per accepted beat.
- Resolves the magnitude relation of the full A and B words and holds it behind a valid/ready output handshake.
- Lets the team compare arbitrarily long operands serially using the existing 2-bit comparator.

---
 rtl/serial_mag_compare.sv | 136 +++++++++++++
 tb/tb_serial_mag_compare.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: folds per-digit flags (MSB digit first) into a word-level
// gt/lt/eq result behind a valid/ready handshake. Optional SERIAL_CMP_FLAG_CHECK_EN adds flag_err.
`timescale 1ns/1ps
module serial_mag_compare #(
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_flags,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq,
    output logic [CNT_W-1:0] out_len,
    output logic             out_len_err
`ifdef SERIAL_CMP_FLAG_CHECK_EN
    ,
    output logic             flag_err
`endif
);

    localparam logic [1:0] EQUAL = 2'd0;
    localparam logic [1:0] GT    = 2'd1;
    localparam logic [1:0] LT    = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    logic [1:0]       state_reg;
    logic [1:0]       rel_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             gt_reg;
    logic             lt_reg;
    logic             eq_reg;
    logic [CNT_W-1:0] len_reg;
    logic             len_err_reg;
    logic             accept;
    logic             pop;
    logic             word_end;

    assign out_valid = (state_reg == HOLD);
    assign in_ready  = !out_valid;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Once a difference is seen the relation is frozen: the most significant difference wins.
    always_comb begin
        rel_next = state_reg;
        if (state_reg == EQUAL) begin
            if (in_flags[2])
                rel_next = GT;
            else if (in_flags[3])
                rel_next = LT;
        end
    end

    assign cnt_next = (cnt_reg == MAX_CNT) ? cnt_reg : cnt_reg + 1'b1;
    assign word_end = in_last || (cnt_next == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= EQUAL;
            cnt_reg     <= '0;
            gt_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            len_reg     <= '0;
            len_err_reg <= 1'b0;
        end else if (pop) begin
            state_reg   <= EQUAL;
            cnt_reg     <= '0;
            gt_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            len_reg     <= '0;
            len_err_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg <= cnt_next;
            if (word_end) begin
                state_reg   <= HOLD;
                gt_reg      <= (rel_next == GT);
                lt_reg      <= (rel_next == LT);
                eq_reg      <= (rel_next == EQUAL);
                len_reg     <= cnt_next;
                len_err_reg <= !in_last;
            end else begin
                state_reg <= rel_next;
            end
        end
    end

    assign out_gt      = gt_reg;
    assign out_lt      = lt_reg;
    assign out_eq      = eq_reg;
    assign out_len     = len_reg;
    assign out_len_err = len_err_reg;

`ifdef SERIAL_CMP_FLAG_CHECK_EN
    logic err_reg;
    logic beat_bad;

    // A consistent vector is exactly one of eq/gt/lt with the derived bits matching it.
    always_comb begin
        beat_bad = 1'b0;
        if ((32'(in_flags[0]) + 32'(in_flags[2]) + 32'(in_flags[3])) != 32'd1)
            beat_bad = 1'b1;
        if (in_flags[1] != !in_flags[0])
            beat_bad = 1'b1;
        if (in_flags[4] != (in_flags[2] | in_flags[0]))
            beat_bad = 1'b1;
        if (in_flags[5] != (in_flags[3] | in_flags[0]))
            beat_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if (pop)
            err_reg <= 1'b0;
        else if (accept)
            err_reg <= err_reg | beat_bad;
    end

    assign flag_err = out_valid & err_reg;
`else
    logic unused_flags;
    assign unused_flags = ^{in_flags[5:4], in_flags[1]};
`endif

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare: driver pushes expected word results computed from
// whole-word integer comparison; an independent monitor pops and checks on each presented result.
`timescale 1ns/1ps
module tb_serial_mag_compare;

    localparam int MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_flags = 6'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_gt, out_lt, out_eq;
    logic [3:0] out_len;
    logic       out_len_err;
`ifdef SERIAL_CMP_FLAG_CHECK_EN
    logic       flag_err;
`endif

    serial_mag_compare #(.MAX_DIGITS(MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_flags(in_flags), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq),
        .out_len(out_len), .out_len_err(out_len_err)
`ifdef SERIAL_CMP_FLAG_CHECK_EN
        , .flag_err(flag_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic gt, lt, eq;
        int   len;
        logic len_err;
        logic ferr;
        int   end_cyc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic       force_stall = 1'b0;
    logic [1:0] wa[$];
    logic [1:0] wb[$];
    logic       werr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [5:0] flags_of(input logic [1:0] a, input logic [1:0] b);
        return {a <= b, a >= b, a < b, a > b, a != b, a == b};
    endfunction

    function automatic logic legit(input logic [5:0] f);
        return (f == 6'b110001) || (f == 6'b010110) || (f == 6'b101010);
    endfunction

    // Reference: the word result is the integer comparison of the concatenated digits.
    task automatic model_accept(input logic [1:0] a, input logic [1:0] b, input logic [5:0] f,
                                input logic last, input int c);
        longint av = 0;
        longint bv = 0;
        exp_t   e;
        wa.push_back(a);
        wb.push_back(b);
        werr = werr | !legit(f);
        if (last || wa.size() == MAX) begin
            foreach (wa[i]) begin
                av = av * 4 + longint'(wa[i]);
                bv = bv * 4 + longint'(wb[i]);
            end
            e.gt = av > bv; e.lt = av < bv; e.eq = av == bv;
            e.len = wa.size(); e.len_err = !last; e.ferr = werr; e.end_cyc = c;
            q.push_back(e);
            wa.delete(); wb.delete(); werr = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [1:0] a, input logic [1:0] b, input logic [5:0] f,
                             input logic last);
        int n = 0;
        in_valid = 1'b1; in_flags = f; in_last = last;
        while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(a, b, f, last, cyc);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input logic [1:0] a, input logic [1:0] b, input logic last);
        send_beat(a, b, flags_of(a, b), last);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 2000) begin @(posedge clk); #1; n++; end
        if (q.size() != 0 || out_valid) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", q.size());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare a newly presented result, hold it stable while stalled, pop on handshake.
    logic showing = 1'b0;
    logic popped = 1'b0;
    logic s_gt, s_lt, s_eq, s_err;
    logic [3:0] s_len;
    always @(negedge clk) begin
        if (!rst_n) begin
            showing = 1'b0; popped = 1'b0;
        end else begin
            if (popped) begin
                chk("pop_valid_low", int'(out_valid), 0);
                chk("pop_ready_high", int'(in_ready), 1);
                popped = 1'b0;
            end
            chk("in_ready_vs_valid", int'(in_ready), int'(!out_valid));
            if (!out_valid) begin
                chk("idle_result_zero", int'({out_gt, out_lt, out_eq}), 0);
            end else if (!showing) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: out_valid 1 expected 0");
                end else begin
                    chk("latency", cyc, q[0].end_cyc + 1);
                    chk("out_gt", int'(out_gt), int'(q[0].gt));
                    chk("out_lt", int'(out_lt), int'(q[0].lt));
                    chk("out_eq", int'(out_eq), int'(q[0].eq));
                    chk("out_len", int'(out_len), q[0].len);
                    chk("out_len_err", int'(out_len_err), int'(q[0].len_err));
`ifdef SERIAL_CMP_FLAG_CHECK_EN
                    chk("flag_err", int'(flag_err), int'(q[0].ferr));
`endif
                    {s_gt, s_lt, s_eq, s_len, s_err} = {out_gt, out_lt, out_eq, out_len, out_len_err};
                    showing = 1'b1;
                end
            end else begin
                chk("hold_stable", int'({out_gt, out_lt, out_eq, out_len, out_len_err}),
                    int'({s_gt, s_lt, s_eq, s_len, s_err}));
            end
            if (out_valid && out_ready && showing) begin
                void'(q.pop_front());
                showing = 1'b0;
                popped = 1'b1;
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, int'({out_valid, out_gt, out_lt, out_eq, out_len, out_len_err}), 0);
        chk({name, "_ready"}, int'(in_ready), 1);
`ifdef SERIAL_CMP_FLAG_CHECK_EN
        chk({name, "_flag_err"}, int'(flag_err), 0);
`endif
    endtask

    initial begin
        logic [1:0] a, b;
        logic [5:0] f, junk;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset_state");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed words from the test plan.
        send(2'b10, 2'b10, 1'b0); send(2'b01, 2'b01, 1'b1);
        send(2'b11, 2'b10, 1'b0); send(2'b00, 2'b11, 1'b1);
        send(2'b01, 2'b01, 1'b0); send(2'b00, 2'b10, 1'b0); send(2'b11, 2'b00, 1'b1);
        drain();

        // Stalled consumer: result must hold with in_ready low.
        force_stall = 1'b1;
        @(posedge clk); #1;
        send(2'b10, 2'b01, 1'b1);
        repeat (6) @(posedge clk);
        #1 force_stall = 1'b0;
        drain();

        // Truncation at MAX digits, then the next beat opens a new word.
        for (int i = 0; i < MAX; i++) send(2'(i), 2'(i), 1'b0);
        send(2'b01, 2'b00, 1'b1);
        drain();

        // Reset mid-word discards the partial GT word.
        send(2'b11, 2'b00, 1'b0); send(2'b01, 2'b01, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        wa.delete(); wb.delete(); werr = 1'b0; q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(2'b00, 2'b01, 1'b1);
        drain();

`ifdef SERIAL_CMP_FLAG_CHECK_EN
        send_beat(2'b01, 2'b00, 6'b000101, 1'b1);
        drain();
`endif

        // Randomized words: biased toward equal digits, with null and junk-bit beats.
        for (int i = 0; i < 300; i++) begin
            a = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) != 0) ? a : 2'($urandom_range(0, 3));
            f = flags_of(a, b);
            junk = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00,
                    1'($urandom_range(0, 1)), 1'b0};
            if ($urandom_range(0, 15) == 0) begin
                a = 2'b00; b = 2'b00; f = junk;
            end
`ifndef SERIAL_CMP_FLAG_CHECK_EN
            else if ($urandom_range(0, 3) == 0) f = f ^ junk;
`endif
            send_beat(a, b, f, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
